// File: rtl/hex_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pkg
// Purpose  : Register map offsets, CTRL field positions and shared types for
//            the seven-segment display peripheral.
// Revision : 1.0  initial release
// ============================================================================
package hex_display_pkg;

    localparam int NUM_DIGITS = 6;

    // Word offsets inside the 8-word register window
    localparam logic [2:0] OFF_DIGIT0 = 3'd0;
    localparam logic [2:0] OFF_DIGIT1 = 3'd1;
    localparam logic [2:0] OFF_DIGIT2 = 3'd2;
    localparam logic [2:0] OFF_DIGIT3 = 3'd3;
    localparam logic [2:0] OFF_DIGIT4 = 3'd4;
    localparam logic [2:0] OFF_DIGIT5 = 3'd5;
    localparam logic [2:0] OFF_CTRL   = 3'd6;
    localparam logic [2:0] OFF_STATUS = 3'd7;

    // CTRL field bit positions
    localparam int CTRL_DEC_LSB   = 0;
    localparam int CTRL_BLINK_LSB = 6;
    localparam int CTRL_BLANK_BIT = 15;

    // Active-low segment value that turns every segment off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Stored CTRL fields: global blank, per-digit blink and decode enables
    typedef struct packed {
        logic       blank_all;
        logic [5:0] blink_en;
        logic [5:0] dec_en;
    } ctrl_t;

endpackage : hex_display_pkg
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : Combinational hex nibble to seven-segment decoder, active-high
//            outputs, bit0 = segment a ... bit6 = segment g.
// Revision : 1.0  initial release
// ============================================================================
module seg7_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Glyph lookup for 0-9 and A, b, C, d, E, F
    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/hex_display_port.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_port
// Purpose  : Memory-mapped six-digit seven-segment display peripheral with
//            raw/decoded digits, per-digit blink, global blank and
//            registered read-back.
// Revision : 1.0  initial release
// ============================================================================
module hex_display_port
    import hex_display_pkg::*;
#(
    parameter int             A_W       = 16,
    parameter int             D_W       = 16,
    parameter logic [A_W-1:0] BASE_ADDR = 16'h2000,
    parameter int             BLINK_DIV = 25000000
) (
    input  logic           CLOCK_50,
    input  logic           Reset,
    input  logic [A_W-1:0] ADDR,
    input  logic [D_W-1:0] DOUT,
    input  logic           W,
    output logic [D_W-1:0] RDATA,
    output logic [6:0]     HEX0,
    output logic [6:0]     HEX1,
    output logic [6:0]     HEX2,
    output logic [6:0]     HEX3,
    output logic [6:0]     HEX4,
    output logic [6:0]     HEX5
);

    localparam int                c_cnt_w   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(BLINK_DIV - 1);

    logic [NUM_DIGITS-1:0][6:0] r_digit;
    ctrl_t                      r_ctrl;
    logic [c_cnt_w-1:0]         r_blink_cnt;
    logic                       r_phase;
    logic [NUM_DIGITS-1:0][6:0] r_hex;

    logic                       w_hit;
    logic [2:0]                 w_off;
    logic [D_W-1:0]             w_rd_val;
    logic [NUM_DIGITS-1:0][6:0] w_dec;
    logic [NUM_DIGITS-1:0][6:0] w_lit;
    logic                       w_unused_dout;

    assign w_hit         = (ADDR[A_W-1:3] == BASE_ADDR[A_W-1:3]);
    assign w_off         = ADDR[2:0];
    assign w_unused_dout = ^DOUT[14:12];

    // Register file update: DIGIT and CTRL writes; STATUS and misses ignored
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_digit <= '0;
            r_ctrl  <= '0;
        end else if (W && w_hit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_off == 3'(i)) begin
                    r_digit[i] <= DOUT[6:0];
                end
            end
            if (w_off == OFF_CTRL) begin
                r_ctrl.blank_all <= DOUT[CTRL_BLANK_BIT];
                r_ctrl.blink_en  <= DOUT[CTRL_BLINK_LSB +: 6];
                r_ctrl.dec_en    <= DOUT[CTRL_DEC_LSB +: 6];
            end
        end
    end

    // Free-running blink divider; phase flips each time the count wraps
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == c_cnt_max) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Read mux on the pre-write register contents
    always_comb begin
        w_rd_val = '0;
        if (w_hit) begin
            if (w_off == OFF_CTRL) begin
                w_rd_val = D_W'({r_ctrl.blank_all, 3'b000, r_ctrl.blink_en, r_ctrl.dec_en});
            end else if (w_off == OFF_STATUS) begin
                w_rd_val = D_W'(r_phase);
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (w_off == 3'(i)) begin
                        w_rd_val = D_W'(r_digit[i]);
                    end
                end
            end
        end
    end

    // Read data register, one cycle latency, sampled every cycle
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            RDATA <= '0;
        end else begin
            RDATA <= w_rd_val;
        end
    end

    // Per-digit segment source selection with blank/blink gating
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        seg7_decode u_seg7_decode (
            .i_nibble (r_digit[gi][3:0]),
            .o_seg    (w_dec[gi])
        );

        assign w_lit[gi] = (r_ctrl.blank_all || (r_ctrl.blink_en[gi] && r_phase)) ? 7'h00 :
                           (r_ctrl.dec_en[gi] ? w_dec[gi] : r_digit[gi]);
    end

    // Output flops, inverted to drive active-low segments
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_hex[i] <= SEG_BLANK;
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_hex[i] <= ~w_lit[i];
            end
        end
    end

    assign HEX0 = r_hex[0];
    assign HEX1 = r_hex[1];
    assign HEX2 = r_hex[2];
    assign HEX3 = r_hex[3];
    assign HEX4 = r_hex[4];
    assign HEX5 = r_hex[5];

endmodule : hex_display_port
`default_nettype wire

// File: tb/tb_hex_display_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_port
// Purpose  : Self-checking bench for hex_display_port: directed vector table,
//            blink sequence and randomized traffic against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_hex_display_port;

    localparam int          BLINK = 4;
    localparam logic [15:0] BASE  = 16'h2000;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        w;
    logic [15:0] rdata;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int n_vec;
    int n_miss;

    hex_display_port #(
        .A_W       (16),
        .D_W       (16),
        .BASE_ADDR (BASE),
        .BLINK_DIV (BLINK)
    ) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .ADDR     (addr),
        .DOUT     (dout),
        .W        (w),
        .RDATA    (rdata),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16];
    logic [6:0] m_digit [6];
    logic [5:0] m_dec;
    logic [5:0] m_blink;
    logic       m_blank;
    int         m_ticks;
    bit         m_valid;

    function automatic logic m_phase();
        return ((m_ticks / BLINK) % 2) == 1;
    endfunction

    function automatic logic m_hit(input logic [15:0] a);
        return (a >> 3) == (BASE >> 3);
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        int off;
        off = int'(a[2:0]);
        if (!m_hit(a)) return 16'h0000;
        if (off == 6) return {m_blank, 3'b000, m_blink, m_dec};
        if (off == 7) return {15'b0, m_phase()};
        return {9'b0, m_digit[off]};
    endfunction

    function automatic logic [6:0] m_hex(input int i);
        logic [6:0] lit;
        lit = m_dec[i] ? seg_tab[int'(m_digit[i][3:0])] : m_digit[i];
        if (m_blank || (m_blink[i] && m_phase())) lit = 7'h00;
        return ~lit;
    endfunction

    function automatic logic [6:0] get_hex(input int i);
        case (i)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            3: return hex3;
            4: return hex4;
            default: return hex5;
        endcase
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge
    task automatic step(input logic r, input logic wv, input logic [15:0] a, input logic [15:0] d);
        logic [15:0] e_rd;
        logic [6:0]  e_hex [6];
        if (r) begin
            e_rd = 16'h0000;
            for (int i = 0; i < 6; i++) e_hex[i] = 7'h7F;
        end else begin
            e_rd = m_read(a);
            for (int i = 0; i < 6; i++) e_hex[i] = m_hex(i);
        end
        rst = r; w = wv; addr = a; dout = d;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 6; i++) m_digit[i] = 7'h00;
            m_dec = '0; m_blink = '0; m_blank = 1'b0; m_ticks = 0; m_valid = 1'b1;
        end else begin
            if (wv && m_hit(a)) begin
                if (a[2:0] < 3'd6) m_digit[int'(a[2:0])] = d[6:0];
                else if (a[2:0] == 3'd6) begin
                    m_dec = d[5:0]; m_blink = d[11:6]; m_blank = d[15];
                end
            end
            m_ticks++;
        end
        #1;
        if (m_valid) begin
            chk("model_rdata", rdata, e_rd);
            for (int i = 0; i < 6; i++) chk($sformatf("model_hex%0d", i), {9'b0, get_hex(i)}, {9'b0, e_hex[i]});
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        r;
        logic        wv;
        logic [15:0] a;
        logic [15:0] d;
        logic        chk_rd;
        logic [15:0] exp_rd;
        int          hidx;
        logic [6:0]  exp_hex;
    } vec_t;

    vec_t tbl [27];

    initial begin
        logic seen_on, seen_off;
        n_vec = 0; n_miss = 0; m_valid = 1'b0; m_ticks = 0;
        m_dec = '0; m_blink = '0; m_blank = 1'b0;
        for (int i = 0; i < 6; i++) m_digit[i] = 7'h00;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        rst = 1'b1; w = 1'b0; addr = '0; dout = '0;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 0, 7'h7F};
        tbl[1]  = '{1'b1, 1'b1, 16'h2000, 16'h0006, 1'b1, 16'h0000, 0, 7'h7F};
        tbl[2]  = '{1'b0, 1'b0, 16'h2006, 16'h0000, 1'b1, 16'h0000, 0, 7'h7F};
        tbl[3]  = '{1'b0, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000, 0, 7'h7F};
        tbl[4]  = '{1'b0, 1'b1, 16'h2000, 16'h0006, 1'b1, 16'h0000, 0, 7'h7F};
        tbl[5]  = '{1'b0, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0006, 0, 7'h79};
        tbl[6]  = '{1'b0, 1'b1, 16'h2006, 16'h0002, 1'b1, 16'h0000, 1, 7'h7F};
        tbl[7]  = '{1'b0, 1'b1, 16'h2001, 16'h000A, 1'b1, 16'h0000, 1, 7'h40};
        tbl[8]  = '{1'b0, 1'b0, 16'h2001, 16'h0000, 1'b1, 16'h000A, 1, 7'h08};
        tbl[9]  = '{1'b0, 1'b1, 16'h2001, 16'h00FA, 1'b1, 16'h000A, 1, 7'h08};
        tbl[10] = '{1'b0, 1'b0, 16'h2001, 16'h0000, 1'b1, 16'h007A, 1, 7'h08};
        tbl[11] = '{1'b0, 1'b1, 16'h2003, 16'h1234, 1'b1, 16'h0000, 0, 7'h79};
        tbl[12] = '{1'b0, 1'b0, 16'h2003, 16'h0000, 1'b1, 16'h0034, 3, 7'h4B};
        tbl[13] = '{1'b0, 1'b1, 16'h2006, 16'h8002, 1'b1, 16'h0002, 0, 7'h79};
        tbl[14] = '{1'b0, 1'b0, 16'h2006, 16'h0000, 1'b1, 16'h8002, 0, 7'h7F};
        tbl[15] = '{1'b0, 1'b0, 16'h2003, 16'h0000, 1'b1, 16'h0034, 3, 7'h7F};
        tbl[16] = '{1'b0, 1'b1, 16'h2006, 16'h0002, 1'b1, 16'h8002, 1, 7'h7F};
        tbl[17] = '{1'b0, 1'b0, 16'h2006, 16'h0000, 1'b1, 16'h0002, 1, 7'h08};
        tbl[18] = '{1'b0, 1'b1, 16'h2010, 16'h0055, 1'b1, 16'h0000, 0, 7'h79};
        tbl[19] = '{1'b0, 1'b0, 16'h2010, 16'h0000, 1'b1, 16'h0000, 0, 7'h79};
        tbl[20] = '{1'b0, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0006, 0, 7'h79};
        tbl[21] = '{1'b0, 1'b1, 16'h2007, 16'hFFFF, 1'b0, 16'h0000, 0, 7'h79};
        tbl[22] = '{1'b0, 1'b0, 16'h2006, 16'h0000, 1'b1, 16'h0002, 1, 7'h08};
        tbl[23] = '{1'b0, 1'b1, 16'h2006, 16'h703F, 1'b1, 16'h0002, 0, 7'h79};
        tbl[24] = '{1'b0, 1'b0, 16'h2006, 16'h0000, 1'b1, 16'h003F, 0, 7'h02};
        tbl[25] = '{1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000, 0, 7'h7F};
        tbl[26] = '{1'b0, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000, 0, 7'h7F};

        for (int k = 0; k < 27; k++) begin
            step(tbl[k].r, tbl[k].wv, tbl[k].a, tbl[k].d);
            if (tbl[k].chk_rd) chk($sformatf("tbl%0d_rdata", k), rdata, tbl[k].exp_rd);
            chk($sformatf("tbl%0d_hex%0d", k, tbl[k].hidx), {9'b0, get_hex(tbl[k].hidx)}, {9'b0, tbl[k].exp_hex});
        end

        // Blink: HEX0 and STATUS[0] read-back must move together
        step(1'b1, 1'b0, 16'h2000, 16'h0000);
        step(1'b0, 1'b1, 16'h2006, 16'h0040);
        step(1'b0, 1'b1, 16'h2000, 16'h003F);
        seen_on = 1'b0; seen_off = 1'b0;
        for (int k = 0; k < 24; k++) begin
            step(1'b0, 1'b0, 16'h2007, 16'h0000);
            chk("blink_in_step", {9'b0, hex0}, rdata[0] ? 16'h007F : 16'h0040);
            if (hex0 == 7'h40) seen_on = 1'b1;
            if (hex0 == 7'h7F) seen_off = 1'b1;
        end
        chk("blink_both_phases", {14'b0, seen_on, seen_off}, 16'h0003);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic        r, wv;
            logic [15:0] a, d;
            r  = ($urandom_range(0, 49) == 0);
            wv = ($urandom_range(0, 1) == 1);
            a  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : (BASE | 16'($urandom_range(0, 7)));
            d  = 16'($urandom);
            step(r, wv, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_hex_display_port
`default_nettype wire

// File: doc/hex_display_port.md
Name: hex_display_port

Overview:
- Memory-mapped seven-segment display peripheral sitting directly downstream of the enhanced processor's data bus.
- The processor stores to it through ADDR/DOUT/W; the block drives the board HEX0..HEX5 outputs.
- Each digit has a raw pattern register, with optional per-digit hex decode, per-digit blink and global blank.
- Registered read-back lets the processor load display state through its read mux.

Parameters:
- BASE_ADDR, 16'h2000, word address of register window; must be 8-aligned (8 words).
- BLINK_DIV, 25000000, clock cycles per blink half-period; minimum 2.
- A_W, 16, address width.
- D_W, 16, data width.

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ADDR  in  A_W  processor word address.
- DOUT  in  D_W  processor store data.
- W  in  1  processor write strobe, one cycle per store.
- RDATA  out  D_W  registered read data; zero when address misses.
- HEX0..HEX5  out  7 each  segment drives, active-low; bit0=a ... bit6=g.

Behaviour:
- Interface: one clock, CLOCK_50; reset is synchronous and active-high, port Reset.
- Hit: ADDR[A_W-1:3] == BASE_ADDR[A_W-1:3]; offset = ADDR[2:0].
- Register map:
  - offsets 0-5: DIGITi[6:0], raw active-high pattern, or nibble in [3:0] when decoding.
  - offset 6: CTRL. [5:0] DEC_EN per digit, [11:6] BLINK_EN per digit, [15] BLANK_ALL.
  - offset 7: STATUS, read-only. [0] blink phase; writes ignored.
- Write: on a rising edge with W=1 and a hit, the register takes DOUT. DIGIT keeps [6:0]; CTRL keeps [15] and [11:0]. Unused bits read 0.
- Read: RDATA <= hit ? reg[offset] : 0 every cycle, regardless of W. Latency is 1 cycle.
- Read/write same cycle, same address: RDATA returns the pre-write value.
- Blink counter:
  - counts 0..BLINK_DIV-1, then wraps to 0 and toggles phase. Free-running.
  - not cleared by CTRL writes.
- Digit pipeline, per digit i:
  - lit = DEC_EN[i] ? seg7(DIGITi[3:0]) : DIGITi[6:0].
  - if BLANK_ALL, or (BLINK_EN[i] and phase==1), lit = 0.
  - HEXi <= ~lit, registered. HEX reflects a write 2 edges after the write's W edge (register, then output flop).
- seg7 table:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71
- Reset:
  - all DIGIT, CTRL, counter and phase = 0; RDATA = 0; HEX0..HEX5 = 7'h7F (dark).
  - Reset has priority over a coincident write.
  - Mid-operation Reset blanks the display on the next edge.
- Writes to misses, or to offset 7, change no state.

Decomposition:
- Package hex_display_pkg:
  - offset constants OFF_DIGIT0..5, OFF_CTRL, OFF_STATUS.
  - CTRL field bit positions.
  - SEG_BLANK = 7'h7F.
- Sub-module seg7_decode: combinational 4-bit to 7-bit active-high decoder, instantiated 6 times.

Test Plan:
1. Reset held 2 cycles, then released -> HEX0..HEX5 = 7F, RDATA = 0; read offset 6 -> 0000.
2. W to 0x2000 with DOUT 0x0006 -> HEX0 = 79 two edges later; read 0x2000 -> RDATA 0006 after 1 cycle.
3. Write CTRL 0x0002, then DIGIT1 = 0x000A -> HEX1 = 08 (~77). Write DIGIT1 = 0x00FA -> still 08 (decode uses [3:0]).
4. BLINK_DIV=4, CTRL 0x0040, DIGIT0 = 0x3F:
   - HEX0 alternates 40 / 7F every 4 cycles.
   - STATUS[0] reads toggle in step with it.
5. Write CTRL 0x8000 -> all HEX = 7F. Write CTRL 0 -> patterns restored unchanged.
6. Edge cases:
   - W to 0x2010 -> no state change, RDATA 0.
   - W and read to 0x2003 in the same cycle -> RDATA shows old value.
   - Reset asserted together with W -> write dropped.
